// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared constants and helpers for the LED fade PWM block.
//   LED_N        default number of LED channels
//   PWM_BITS_DEF default PWM counter / brightness width
//   pwm_max()    full-scale value (2^width - 1) for a given width
//   gamma_duty() square-law duty correction, used when LED_FADE_GAMMA_EN is defined
package led_fade_pkg;

  localparam int unsigned LED_N        = 8;
  localparam int unsigned PWM_BITS_DEF = 8;

  // Full-scale brightness for a counter of the given width.
  function automatic int unsigned pwm_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Perceptual correction: duty^2 scaled back to the duty range; full scale
  // is pinned so a lit LED still gets a constant-on output.
  function automatic int unsigned gamma_duty(input int unsigned duty,
                                             input int unsigned width);
    int unsigned max_v;
    int unsigned prod;
    max_v = pwm_max(width);
    prod  = duty * duty;
    if (duty == max_v) begin
      return max_v;
    end
    return prod >> width;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: brightness, shadow duty and PWM compare for one LED.
// Optional build macro: LED_FADE_GAMMA_EN (gamma-corrected compare).
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   lit       registered input bit for this channel (1 = commanded on)
//   tick      one-cycle decay strobe
//   pwm_cnt   shared free-running PWM counter
//   pwm_wrap  high on the cycle pwm_cnt is at full scale (period boundary)
//   pwm_out   registered PWM drive for this LED
//   fading    combinational: brightness nonzero while not lit
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned         PWM_BITS   = PWM_BITS_DEF,
  parameter logic [PWM_BITS-1:0] DECAY_STEP = PWM_BITS'(32)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lit,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                pwm_wrap,
  output logic                pwm_out,
  output logic                fading
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));

  logic [PWM_BITS-1:0] bright;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] cmp_duty;

  // Duty value fed to the comparator.
`ifdef LED_FADE_GAMMA_EN
  always_comb begin
    cmp_duty = PWM_BITS'(gamma_duty(32'(duty), PWM_BITS));
  end
`else
  always_comb begin
    cmp_duty = duty;
  end
`endif

  // Brightness update, shadow duty capture at the period boundary, and the
  // registered compare. Full-scale duty is forced high so a lit LED never
  // drops out on the last count of the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      bright  <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (lit) begin
        bright <= MAX;
      end else if (tick) begin
        bright <= (bright > DECAY_STEP) ? (bright - DECAY_STEP) : '0;
      end

      if (pwm_wrap) begin
        duty <= bright;
      end

      pwm_out <= (cmp_duty == MAX) ? 1'b1 : (pwm_cnt < cmp_duty);
    end
  end

  assign fading = (bright != '0) && !lit;

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-channel PWM fader between the LED chaser and the LED pins.
// A lit input holds its channel at full brightness; when it drops, brightness
// decays linearly to zero, leaving a fading tail behind the moving LED.
// Optional build macro: LED_FADE_GAMMA_EN (gamma-corrected compare in channels).
// Ports:
//   clk          system clock, single domain
//   rst          synchronous active-high reset
//   led_in       [N] chaser pattern, 1 = LED commanded on
//   led_pwm      [N] registered PWM drive, 1 = LED on
//   tail_active  registered: some channel is fading (bright != 0, not lit)
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int unsigned         N          = LED_N,
  parameter int unsigned         PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned         DECAY_DIV  = 1_350_000,
  parameter logic [PWM_BITS-1:0] DECAY_STEP = PWM_BITS'(32)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] led_in,
  output logic [N-1:0] led_pwm,
  output logic         tail_active
);

  localparam int unsigned         DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX      = PWM_BITS'(pwm_max(PWM_BITS));

  logic [N-1:0]        led_q;
  logic [N-1:0]        fading;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_wrap;

  assign pwm_wrap = (pwm_cnt == MAX);

  // Input register, decay divider/tick, free-running PWM counter, fade flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= '0;
      div_cnt     <= '0;
      tick        <= 1'b0;
      pwm_cnt     <= '0;
      tail_active <= 1'b0;
    end else begin
      led_q       <= led_in;
      div_cnt     <= (div_cnt == DIV_LAST) ? '0 : (div_cnt + DIV_W'(1));
      tick        <= (div_cnt == DIV_LAST);
      pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
      tail_active <= |fading;
    end
  end

  // One independent fader per LED.
  for (genvar i = 0; i < N; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .lit      (led_q[i]),
      .tick     (tick),
      .pwm_cnt  (pwm_cnt),
      .pwm_wrap (pwm_wrap),
      .pwm_out  (led_pwm[i]),
      .fading   (fading[i])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: directed checks of led_fade_pwm with PWM_BITS=4 (MAX=15),
// DECAY_DIV=20, DECAY_STEP=4. edge_no counts clock edges since reset release;
// ticks land on edges 21,41,61,... and duty captures on edges 16,32,48,...
module tb_led_fade_pwm;

  localparam int unsigned N    = 8;
  localparam int unsigned PB   = 4;
  localparam int unsigned HIST = 512;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] led_in;
  logic [N-1:0] led_pwm;
  logic         tail_active;

  led_fade_pwm #(
    .N          (N),
    .PWM_BITS   (PB),
    .DECAY_DIV  (20),
    .DECAY_STEP (4'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .led_in      (led_in),
    .led_pwm     (led_pwm),
    .tail_active (tail_active)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   edge_no;
  int   hi_cnt [N];
  int   tail_cnt;
  logic tail_hist [HIST];

  typedef struct {
    logic [N-1:0] drive;
    int           ch0_hi;
    int           others_hi;
    logic         tail_end;
    logic [N-1:0] pwm_end;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
    tail_cnt = 0;
  endtask

  // Drive inputs, take one edge, sample on the following falling edge.
  task automatic step(input logic [N-1:0] drv);
    led_in = drv;
    @(posedge clk);
    @(negedge clk);
    edge_no++;
    for (int i = 0; i < N; i++) if (led_pwm[i]) hi_cnt[i]++;
    if (tail_active) tail_cnt++;
    if (edge_no >= 0 && edge_no < HIST) tail_hist[edge_no] = tail_active;
  endtask

  task automatic run_to(input int last, input logic [N-1:0] drv);
    while (edge_no < last) step(drv);
  endtask

  function automatic logic [N-1:0] chase_pat(input int e);
    logic [N-1:0] p;
    p = 8'h01;
    return p << (((e - 1) / 40) % 8);
  endfunction

  task automatic run_chase_to(input int last);
    while (edge_no < last) step(chase_pat(edge_no + 1));
  endtask

  int others;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // drive, ch0 on-cycles, other on-cycles, tail at end, led_pwm at end
    vecs[0] = '{8'h01,  0, 0, 1'b0, 8'h00};
    vecs[1] = '{8'h01, 16, 0, 1'b0, 8'h01};
    vecs[2] = '{8'h00, 16, 0, 1'b1, 8'h01};
    vecs[3] = '{8'h00, 11, 0, 1'b1, 8'h00};
    vecs[4] = '{8'h00,  7, 0, 1'b1, 8'h00};
    vecs[5] = '{8'h00,  7, 0, 1'b1, 8'h00};
    vecs[6] = '{8'h00,  3, 0, 1'b0, 8'h00};
    vecs[7] = '{8'h00,  0, 0, 1'b0, 8'h00};

    // Reset with all inputs high: outputs must stay low.
    rst     = 1'b1;
    led_in  = 8'hFF;
    edge_no = 0;
    clear_cnt();
    for (int r = 0; r < 3; r++) begin
      step(8'hFF);
      check($sformatf("reset%0d led_pwm", r), int'(led_pwm), 0);
      check($sformatf("reset%0d tail_active", r), int'(tail_active), 0);
    end
    rst     = 1'b0;
    edge_no = 0;

    // Full-on then decay of channel 0, one 16-edge PWM period per record.
    for (int v = 0; v < 8; v++) begin
      clear_cnt();
      for (int k = 0; k < 16; k++) step(vecs[v].drive);
      others = 0;
      for (int i = 1; i < N; i++) others += hi_cnt[i];
      check($sformatf("tbl%0d ch0 on-cycles", v), hi_cnt[0], vecs[v].ch0_hi);
      check($sformatf("tbl%0d ch1-7 on-cycles", v), others, vecs[v].others_hi);
      check($sformatf("tbl%0d tail_active", v), int'(tail_active), int'(vecs[v].tail_end));
      check($sformatf("tbl%0d led_pwm", v), int'(led_pwm), int'(vecs[v].pwm_end));
    end
    check("tail edge33", int'(tail_hist[33]), 0);
    check("tail edge34", int'(tail_hist[34]), 1);
    check("tail edge101", int'(tail_hist[101]), 1);
    check("tail edge102", int'(tail_hist[102]), 0);

    // Priority: ch3 relit on the tick cycle while bright=7 snaps back to 15.
    run_to(130, 8'h08);
    run_to(176, 8'h00);
    clear_cnt();
    run_to(179, 8'h00);
    run_to(180, 8'h08);
    run_to(192, 8'h00);
    check("prio ch3 period duty7", hi_cnt[3], 7);
    clear_cnt();
    run_to(208, 8'h00);
    check("prio ch3 period relit", hi_cnt[3], 16);
    clear_cnt();
    run_to(224, 8'h00);
    check("prio ch3 period after tick", hi_cnt[3], 11);
    check("prio tail edge180", int'(tail_hist[180]), 1);
    check("prio tail edge181", int'(tail_hist[181]), 0);
    check("prio tail edge182", int'(tail_hist[182]), 1);

    // Glitch-free: ch5 lit at pwm_cnt=5 leaves the current period dark.
    clear_cnt();
    run_to(229, 8'h00);
    run_to(240, 8'h20);
    check("glitch ch5 current period", hi_cnt[5], 0);
    clear_cnt();
    step(8'h20);
    check("glitch ch5 first count", int'(led_pwm[5]), 1);
    run_to(256, 8'h20);
    check("glitch ch5 next period", hi_cnt[5], 16);

    // Reset while a channel is fully on.
    rst = 1'b1;
    step(8'h20);
    check("midreset led_pwm", int'(led_pwm), 0);
    check("midreset tail_active", int'(tail_active), 0);
    step(8'h00);
    rst     = 1'b0;
    edge_no = 0;

    // Chaser stream: new LED every 40 edges.
    run_chase_to(48);
    clear_cnt();
    run_chase_to(64);
    check("chase w49 ch0", hi_cnt[0], 16);
    check("chase w49 ch1", hi_cnt[1], 16);
    clear_cnt();
    run_chase_to(80);
    check("chase w65 ch0 trailing", hi_cnt[0], 11);
    check("chase w65 ch1 leading", hi_cnt[1], 16);
    clear_cnt();
    run_chase_to(96);
    check("chase w81 ch0", hi_cnt[0], 11);
    check("chase w81 ch1", hi_cnt[1], 16);
    check("chase w81 ch2", hi_cnt[2], 0);
    clear_cnt();
    run_chase_to(104);
    check("chase w97 ch0", hi_cnt[0], 7);
    check("chase w97 ch1", hi_cnt[1], 8);
    check("chase w97 ch2", hi_cnt[2], 8);
    check("chase edge104 led_pwm", int'(led_pwm), 8'h06);
    check("chase edge104 tail", int'(tail_active), 1);

    rst = 1'b1;
    step(chase_pat(105));
    check("chase reset led_pwm", int'(led_pwm), 0);
    check("chase reset tail", int'(tail_active), 0);
    rst     = 1'b0;
    edge_no = 0;
    clear_cnt();
    run_to(32, 8'h00);
    others = 0;
    for (int i = 0; i < N; i++) others += hi_cnt[i];
    check("post-reset residual on-cycles", others, 0);
    check("post-reset residual tail", tail_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
